cpu_ibus_sram_slave: RTL and testbench
======================================

Name: cpu_ibus_sram_slave

Overview:
- Slave/responder end of the CPU instruction-fetch bus: accepts fetch requests (ena, addr) and returns up to two 32-bit instructions (rdata1/rdata2 with valid1/valid2).
- Backed by a 64-bit-wide on-chip instruction memory with a req/gnt/rvalid handshake and variable latency.
- Holds a one-entry line buffer (last fetched 64-bit word), so sequential fetches within one word complete in one cycle.
- Sits between the fetch stage and the instruction SRAM/ROM controller.

Parameters:
- MEM_AW, 16, memory word-address width in 64-bit words; used bits are addr[MEM_AW+2:3].
- BUF_EN, 1, enables the line buffer; when 0, every fetch goes to memory.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- ibus_ena  input  1  fetch request; master holds it and addr stable until it sees valid1=1
- ibus_addr  input  64  fetch byte address; bits [1:0] ignored
- ibus_valid1  output  1  rdata1 valid (one-cycle pulse)
- ibus_valid2  output  1  rdata2 valid (pulses only together with valid1)
- ibus_rdata1  output  32  instruction at addr
- ibus_rdata2  output  32  instruction at addr+4
- mem_req  output  1  memory read request
- mem_addr  output  MEM_AW  memory word address
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  mem_rdata valid; exactly one per granted request, at least 1 cycle after gnt
- mem_rdata  input  64  read word; [31:0] is the lower address
- buf_inv  input  1  invalidate line buffer (fence.i)

Behaviour:
- Reset: valid1=valid2=0, rdata1=rdata2=0, mem_req=0, mem_addr=0, buffer invalid, FSM=IDLE.
- Outputs are registered. Response order: rdata1=word[addr[2]*32 +: 32]. If addr[2]=0, rdata2=word[63:32] and valid2=1. If addr[2]=1, valid2=0 and rdata2=0.
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE: ena=1 with buffer hit (valid and tag == addr[MEM_AW+2:3], BUF_EN=1) -> assert valid on the next edge and stay in IDLE. Latency 1 cycle. Back-to-back hits give 1 response per cycle.
- IDLE: ena=1 with a miss -> latch the word address and go to REQ. mem_req=1 starts the next cycle.
- REQ: hold mem_req and mem_addr until mem_gnt. On gnt, drop mem_req the next cycle and go to WAIT. gnt and rvalid in the same cycle is illegal from memory.
- WAIT: on mem_rvalid, load the buffer (data and tag, valid=1) and go to RESP.
- RESP: drive valid1/valid2 for exactly 1 cycle, then return to IDLE.
- Miss latency = 1 + (cycles to gnt) + (cycles gnt->rvalid) + 1.
- After valid1, the master may present a new request in the same cycle that valid1 is seen. IDLE samples it on the following edge, so no response is ever given for a stale address.
- Cancel: ena=0 in REQ before gnt -> drop mem_req, return to IDLE. ena=0 in WAIT -> go to DRAIN. DRAIN discards the next rvalid (buffer not loaded) and returns to IDLE. No valid pulse is issued for a cancelled fetch. A request arriving during DRAIN waits until IDLE.
- Address change while ena held (protocol violation): not checked; the response uses the latched address.
- buf_inv: clears buffer valid on the next edge and has priority over a same-cycle load. A hit lookup in the same cycle as buf_inv is treated as a miss. A fetch in flight is still answered.
- Reset mid-operation: immediate return to reset values. Any memory rvalid still outstanding after reset is ignored while in IDLE.
- Word-address wrap: addresses beyond 2^MEM_AW words alias (upper bits dropped); the tag uses the truncated address.

Test Plan:
- Reset then ena=1, addr=0x80000000, mem gnt after 2 cycles and rvalid 3 cycles later with rdata=0x11112222_33334444 -> single pulse valid1=valid2=1, rdata1=0x33334444, rdata2=0x11112222; total latency 7 cycles.
- Next fetch addr=0x80000004 (same word) -> valid1=1, valid2=0, rdata1=0x11112222 on the next cycle, no mem_req.
- Hits at 0x80000000 repeated 4 cycles back-to-back -> 4 consecutive valid pulses, mem_req stays 0.
- Miss with ena dropped 1 cycle after gnt, then new fetch at 0x80000010 -> first rvalid discarded, no valid pulse, buffer tag unchanged, second fetch returns the correct data.
- buf_inv pulse, then fetch 0x80000000 -> mem_req reasserted, memory data returned (not stale buffer data).
- rst asserted while in WAIT -> outputs 0 asynchronously; late rvalid ignored; next fetch is a clean miss.

Source files
------------

// File: rtl/cpu_ibus_sram_slave_if.sv
// Instruction-fetch bus bundle: fetch-stage request/response side, the
// fence.i invalidate strobe, and the 64-bit instruction memory handshake.
interface cpu_ibus_sram_slave_if #(
    parameter int MEM_AW = 16
);
    // Fetch side
    logic              ibus_ena;
    logic [63:0]       ibus_addr;
    logic              ibus_valid1;
    logic              ibus_valid2;
    logic [31:0]       ibus_rdata1;
    logic [31:0]       ibus_rdata2;
    logic              buf_inv;

    // Memory side
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    // View of the responder sitting between fetch stage and memory
    modport slave (
        input  ibus_ena, ibus_addr, buf_inv,
        output ibus_valid1, ibus_valid2, ibus_rdata1, ibus_rdata2,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // View of the fetch stage
    modport master (
        output ibus_ena, ibus_addr, buf_inv,
        input  ibus_valid1, ibus_valid2, ibus_rdata1, ibus_rdata2
    );

    // View of the instruction SRAM/ROM controller
    modport memory (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cpu_ibus_sram_slave.sv
// Instruction-fetch responder: serves up to two 32-bit instructions per fetch
// from a one-entry 64-bit line buffer, refilling it from a req/gnt/rvalid
// memory on a miss. Fetches may be cancelled by dropping ena mid-flight.
module cpu_ibus_sram_slave #(
    parameter int MEM_AW = 16,
    parameter bit BUF_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_ibus_sram_slave_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Memory request and the latched fetch address
    logic              r_mem_req;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_addr_hi;

    // Line buffer; the data word also stages the miss response
    logic              r_buf_valid;
    logic [MEM_AW-1:0] r_buf_tag;
    logic [63:0]       r_buf_data;

    // Registered response
    logic              r_valid1;
    logic              r_valid2;
    logic [31:0]       r_rdata1;
    logic [31:0]       r_rdata2;

    logic [MEM_AW-1:0] w_req_word;
    logic              w_hit;
    logic              w_latch;
    logic              w_mem_req_next;
    logic              w_load;
    logic              w_respond;
    logic              w_sel_hi;
    logic [31:0]       w_rdata1;
    logic [31:0]       w_rdata2;
    logic              w_unused;

    // Word address with upper bits dropped, so aliased addresses share a tag
    assign w_req_word = bus.ibus_addr[MEM_AW+2:3];
    assign w_unused   = ^{bus.ibus_addr[63:MEM_AW+3], bus.ibus_addr[1:0]};

    // An invalidate in the lookup cycle forces a miss
    assign w_hit = BUF_EN && r_buf_valid && !bus.buf_inv && (r_buf_tag == w_req_word);

    // Upper half requested: only one instruction is left in the word
    assign w_rdata1 = w_sel_hi ? r_buf_data[63:32] : r_buf_data[31:0];
    assign w_rdata2 = w_sel_hi ? 32'd0 : r_buf_data[63:32];

    // Next-state and control decode
    always_comb begin
        w_state_next   = r_state;
        w_latch        = 1'b0;
        w_mem_req_next = 1'b0;
        w_load         = 1'b0;
        w_respond      = 1'b0;
        w_sel_hi       = r_addr_hi;
        case (r_state)
            IDLE: begin
                if (bus.ibus_ena) begin
                    if (w_hit) begin
                        w_respond = 1'b1;
                        w_sel_hi  = bus.ibus_addr[2];
                    end else begin
                        w_latch        = 1'b1;
                        w_mem_req_next = 1'b1;
                        w_state_next   = REQ;
                    end
                end
            end
            REQ: begin
                // Once granted the memory owes us a beat, so a cancel must drain it
                if (bus.mem_gnt) begin
                    w_state_next = bus.ibus_ena ? WAIT : DRAIN;
                end else if (!bus.ibus_ena) begin
                    w_state_next = IDLE;
                end else begin
                    w_mem_req_next = 1'b1;
                end
            end
            WAIT: begin
                if (!bus.ibus_ena) begin
                    w_state_next = bus.mem_rvalid ? IDLE : DRAIN;
                end else if (bus.mem_rvalid) begin
                    w_load       = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_respond    = 1'b1;
                w_state_next = IDLE;
            end
            DRAIN: begin
                if (bus.mem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory request and latched fetch address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_addr_hi  <= 1'b0;
        end else begin
            r_mem_req <= w_mem_req_next;
            if (w_latch) begin
                r_mem_addr <= w_req_word;
                r_addr_hi  <= bus.ibus_addr[2];
            end
        end
    end

    // Line buffer: invalidate wins over a same-cycle refill, data still lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else begin
            if (bus.buf_inv) begin
                r_buf_valid <= 1'b0;
            end else if (w_load) begin
                r_buf_valid <= 1'b1;
            end
            if (w_load) begin
                r_buf_tag  <= r_mem_addr;
                r_buf_data <= bus.mem_rdata;
            end
        end
    end

    // Registered one-cycle response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            r_valid1 <= w_respond;
            r_valid2 <= w_respond && !w_sel_hi;
            r_rdata1 <= w_respond ? w_rdata1 : 32'd0;
            r_rdata2 <= w_respond ? w_rdata2 : 32'd0;
        end
    end

    assign bus.ibus_valid1 = r_valid1;
    assign bus.ibus_valid2 = r_valid2;
    assign bus.ibus_rdata1 = r_rdata1;
    assign bus.ibus_rdata2 = r_rdata2;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_cpu_ibus_sram_slave.sv
// Bench for cpu_ibus_sram_slave: a memory responder with programmable
// grant/rvalid delays, a transaction-level line-buffer model, directed
// scenarios and a randomized fetch sequence.
module tb_cpu_ibus_sram_slave;
    localparam int MEM_AW = 16;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder configuration and state
    int                resp_g = 1;   // cycles of mem_req up to and including gnt
    int                resp_r = 1;   // cycles from gnt to rvalid
    int                req_cycles = 0;
    int                gnt_cnt = 0;
    int                rv_cnt = -1;
    logic [MEM_AW-1:0] pend_a;
    logic [63:0]       mem_model [int];

    // Line-buffer reference model
    logic              m_valid;
    logic [MEM_AW-1:0] m_tag;
    logic [63:0]       m_data;

    cpu_ibus_sram_slave_if #(.MEM_AW(MEM_AW)) bus ();

    cpu_ibus_sram_slave #(.MEM_AW(MEM_AW), .BUF_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [MEM_AW-1:0] tag_of(input logic [63:0] a);
        return a[MEM_AW+2:3];
    endfunction

    function automatic logic [63:0] mem_read(input logic [MEM_AW-1:0] t);
        logic [31:0] x;
        x = 32'(t);
        if (mem_model.exists(int'(t))) return mem_model[int'(t)];
        return {x * 32'h9E37_79B1 + 32'h1357_9BDF, x ^ 32'hC3A5_5A3C};
    endfunction

    // Memory: grants after resp_g request cycles, returns data resp_r cycles later
    always @(negedge clk) begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_read(pend_a);
                rv_cnt         = -1;
            end
        end
        if (bus.mem_req === 1'b1) begin
            req_cycles++;
            gnt_cnt++;
            if (gnt_cnt >= resp_g && rv_cnt < 0 && !bus.mem_rvalid) begin
                bus.mem_gnt = 1'b1;
                pend_a      = bus.mem_addr;
                rv_cnt      = resp_r;
                gnt_cnt     = 0;
            end
        end else begin
            gnt_cnt = 0;
        end
    end

    // Reference: what a completed fetch of address a must return
    task automatic predict(input logic [63:0] a, output int elat,
                           output logic [31:0] e1, output logic [31:0] e2, output logic ev2);
        logic        hit;
        logic [63:0] w;
        hit  = m_valid && (m_tag == tag_of(a));
        w    = hit ? m_data : mem_read(tag_of(a));
        elat = hit ? 1 : 2 + resp_g + resp_r;
        e1   = a[2] ? w[63:32] : w[31:0];
        e2   = a[2] ? 32'd0 : w[63:32];
        ev2  = !a[2];
        m_valid = 1'b1;
        m_tag   = tag_of(a);
        m_data  = w;
    endtask

    // Master: issue one fetch, hold until valid1, then drop ena
    task automatic fetch(input logic [63:0] a, input logic inv_first, output int lat,
                         output logic [31:0] d1, output logic [31:0] d2,
                         output logic v2, output logic v1_after);
        bus.ibus_addr = a;
        bus.ibus_ena  = 1'b1;
        bus.buf_inv   = inv_first;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus.buf_inv = 1'b0;
            lat++;
        end while (bus.ibus_valid1 !== 1'b1 && lat < 200);
        d1 = bus.ibus_rdata1;
        d2 = bus.ibus_rdata2;
        v2 = bus.ibus_valid2;
        bus.ibus_ena = 1'b0;
        @(posedge clk); #1;
        v1_after = bus.ibus_valid1;
        $display("fetch addr=%h lat=%0d rdata1=%h rdata2=%h valid2=%b", a, lat, d1, d2, v2);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.ibus_valid1 !== 1'b0)
            begin n_err++; $display("FAIL reset_held req=%b v1=%b want 0/0", bus.mem_req, bus.ibus_valid1); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({bus.ibus_valid1, bus.ibus_valid2} !== 2'b00)
            begin n_err++; $display("FAIL reset_valid got %b want 00", {bus.ibus_valid1, bus.ibus_valid2}); end
        n_cmp++; if ({bus.ibus_rdata1, bus.ibus_rdata2} !== 64'd0)
            begin n_err++; $display("FAIL reset_rdata got %h want 0", {bus.ibus_rdata1, bus.ibus_rdata2}); end
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0)
            begin n_err++; $display("FAIL reset_mem req=%b addr=%h want 0", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_first_miss();
        int lat, elat; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        mem_model[0] = 64'h1111_2222_3333_4444;
        resp_g = 2; resp_r = 3;
        predict(64'h8000_0000, elat, e1, e2, ev2);
        fetch(64'h8000_0000, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== 7 || elat !== 7) begin n_err++; $display("FAIL miss_latency got %0d want 7", lat); end
        n_cmp++; if (d1 !== 32'h3333_4444) begin n_err++; $display("FAIL miss_rdata1 got %h want 33334444", d1); end
        n_cmp++; if (d2 !== 32'h1111_2222 || v2 !== 1'b1)
            begin n_err++; $display("FAIL miss_rdata2 got %h/%b want 11112222/1", d2, v2); end
        n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL miss_pulse valid1 after=%b want 0", va); end
    endtask

    task automatic test_same_word_hit();
        int lat, elat, rc0; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        rc0 = req_cycles;
        predict(64'h8000_0004, elat, e1, e2, ev2);
        fetch(64'h8000_0004, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL hit_latency got %0d want %0d", lat, elat); end
        n_cmp++; if (d1 !== e1 || d2 !== e2 || v2 !== ev2)
            begin n_err++; $display("FAIL hit_data got %h %h %b want %h %h %b", d1, d2, v2, e1, e2, ev2); end
        n_cmp++; if (req_cycles !== rc0) begin n_err++; $display("FAIL hit_no_req got %0d req cycles want 0", req_cycles - rc0); end
    endtask

    task automatic test_back_to_back();
        int elat, rc0, pulses; logic [31:0] e1, e2; logic ev2;
        rc0 = req_cycles;
        pulses = 0;
        predict(64'h8000_0000, elat, e1, e2, ev2);
        bus.ibus_addr = 64'h8000_0000;
        bus.ibus_ena  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ibus_valid1 === 1'b1 && bus.ibus_rdata1 === e1 && bus.ibus_rdata2 === e2) pulses++;
            $display("b2b beat %0d valid1=%b rdata1=%h", i, bus.ibus_valid1, bus.ibus_rdata1);
        end
        bus.ibus_ena = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
        n_cmp++; if (bus.ibus_valid1 !== 1'b0) begin n_err++; $display("FAIL b2b_stop valid1=%b want 0", bus.ibus_valid1); end
        n_cmp++; if (req_cycles !== rc0) begin n_err++; $display("FAIL b2b_no_req got %0d want 0", req_cycles - rc0); end
    endtask

    task automatic test_cancel();
        int lat, elat, rc0, n; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        // Cancel while still waiting for the grant
        resp_g = 5; resp_r = 1;
        bus.ibus_addr = 64'h8000_0020;
        bus.ibus_ena  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.ibus_ena = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cancel_req_drop mem_req=%b want 0", bus.mem_req); end
        // Cancel one cycle after the grant: the returning beat must be discarded
        resp_g = 1; resp_r = 4;
        bus.ibus_addr = 64'h8000_0008;
        bus.ibus_ena  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.mem_gnt !== 1'b1 && n < 50);
        n_cmp++; if (n >= 50) begin n_err++; $display("FAIL cancel_gnt_timeout waited %0d want <50", n); end
        @(posedge clk); #1;
        bus.ibus_ena = 1'b0;
        rc0 = req_cycles;
        @(posedge clk); #1;
        // New fetch arrives while draining; buffer must still hold the first word
        predict(64'h8000_0004, elat, e1, e2, ev2);
        fetch(64'h8000_0004, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (d1 !== e1 || v2 !== ev2) begin n_err++; $display("FAIL cancel_next_data got %h/%b want %h/%b", d1, v2, e1, ev2); end
        n_cmp++; if (req_cycles !== rc0) begin n_err++; $display("FAIL cancel_tag_kept got %0d req cycles want 0", req_cycles - rc0); end
        resp_r = 1;
        predict(64'h8000_0010, elat, e1, e2, ev2);
        fetch(64'h8000_0010, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL cancel_refetch_lat got %0d want %0d", lat, elat); end
        n_cmp++; if (d1 !== e1 || d2 !== e2 || v2 !== ev2)
            begin n_err++; $display("FAIL cancel_refetch_data got %h %h %b want %h %h %b", d1, d2, v2, e1, e2, ev2); end
    endtask

    task automatic test_buf_inv();
        int lat, elat, rc0; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        resp_g = 1; resp_r = 2;
        predict(64'h8000_0000, elat, e1, e2, ev2);
        fetch(64'h8000_0000, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== elat || d1 !== e1) begin n_err++; $display("FAIL inv_fill got lat %0d %h want %0d %h", lat, d1, elat, e1); end
        mem_model[0] = 64'hCAFE_F00D_0BAD_BEEF;
        bus.buf_inv = 1'b1;
        @(posedge clk); #1;
        bus.buf_inv = 1'b0;
        m_valid = 1'b0;
        rc0 = req_cycles;
        predict(64'h8000_0000, elat, e1, e2, ev2);
        fetch(64'h8000_0000, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (d1 !== e1 || d2 !== e2) begin n_err++; $display("FAIL inv_fresh_data got %h %h want %h %h", d1, d2, e1, e2); end
        n_cmp++; if (lat !== elat || req_cycles == rc0)
            begin n_err++; $display("FAIL inv_refetch got lat %0d req %0d want lat %0d req>0", lat, req_cycles - rc0, elat); end
        // Invalidate in the same cycle as a would-be hit
        m_valid = 1'b0;
        predict(64'h8000_0004, elat, e1, e2, ev2);
        fetch(64'h8000_0004, 1'b1, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== elat || d1 !== e1)
            begin n_err++; $display("FAIL inv_same_cycle got lat %0d %h want %0d %h", lat, d1, elat, e1); end
    endtask

    task automatic test_reset_mid();
        int lat, elat, n, pulses; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        resp_g = 1; resp_r = 6;
        bus.ibus_addr = 64'h8000_0018;
        bus.ibus_ena  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.mem_gnt !== 1'b1 && n < 50);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_addr !== '0 || bus.mem_req !== 1'b0)
            begin n_err++; $display("FAIL rst_async mem_addr=%h req=%b want 0", bus.mem_addr, bus.mem_req); end
        bus.ibus_ena = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.ibus_valid1 === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_late_rvalid got %0d pulses want 0", pulses); end
        resp_r = 2;
        predict(64'h8000_0000, elat, e1, e2, ev2);
        fetch(64'h8000_0000, 1'b0, lat, d1, d2, v2, va);
        n_cmp++; if (lat !== elat || d1 !== e1 || d2 !== e2)
            begin n_err++; $display("FAIL rst_clean_miss got lat %0d %h %h want %0d %h %h", lat, d1, d2, elat, e1, e2); end
    endtask

    task automatic test_random();
        int lat, elat; logic [31:0] d1, d2, e1, e2; logic v2, ev2, va;
        logic [63:0] a;
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            a[MEM_AW+2:3] = MEM_AW'($urandom_range(0, 5));
            resp_g = $urandom_range(1, 3);
            resp_r = $urandom_range(1, 3);
            if ($urandom_range(0, 5) == 0) begin
                bus.buf_inv = 1'b1;
                @(posedge clk); #1;
                bus.buf_inv = 1'b0;
                m_valid = 1'b0;
            end
            predict(a, elat, e1, e2, ev2);
            fetch(a, 1'b0, lat, d1, d2, v2, va);
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, elat); end
            n_cmp++; if (d1 !== e1 || d2 !== e2 || v2 !== ev2 || va !== 1'b0)
                begin n_err++; $display("FAIL rand_data[%0d] got %h %h %b %b want %h %h %b 0", i, d1, d2, v2, va, e1, e2, ev2); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.ibus_ena  = 1'b0;
        bus.ibus_addr = '0;
        bus.buf_inv   = 1'b0;
        m_valid       = 1'b0;
        m_tag         = '0;
        m_data        = '0;
        test_reset();
        test_first_miss();
        test_same_word_hit();
        test_back_to_back();
        test_cancel();
        test_buf_inv();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
